// File: rtl/mod_counter.sv
// Up/down counter with programmable modulus, variable step, and wrap or saturate arithmetic.
// Latency: 1 cycle to count/wrap/flags. at_max/at_min are combinational. No backpressure; every input is sampled on every edge.
module mod_counter #(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic [WIDTH-1:0]  data,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              at_max,
  output logic              at_min,
  output logic              wrap,
  output logic              ovf,
  output logic              udf
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             ovf_set, udf_set;

  // All arithmetic is one bit wider than the count so sums never truncate.
  logic [WIDTH:0] lim_x, cnt_x, step_x, s_x, sum_x, mod_x, res_x;

  assign lim_x  = {1'b0, limit};
  assign cnt_x  = {1'b0, count_q};
  assign step_x = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign s_x    = (step_x > lim_x) ? lim_x : step_x;
  assign sum_x  = cnt_x + s_x;
  assign mod_x  = lim_x + 1'b1;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    res_x   = '0;
    if (load) begin
      count_d = (data > limit) ? limit : data;
    end else if (en) begin
      if (cnt_x > lim_x) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else if (up_down) begin
        if (sum_x <= lim_x) begin
          count_d = sum_x[WIDTH-1:0];
        end else begin
          wrap_d  = 1'b1;
          ovf_set = 1'b1;
          res_x   = sum_x - mod_x;
          count_d = SATURATE ? limit : res_x[WIDTH-1:0];
        end
      end else begin
        if (cnt_x >= s_x) begin
          res_x   = cnt_x - s_x;
          count_d = res_x[WIDTH-1:0];
        end else begin
          wrap_d  = 1'b1;
          udf_set = 1'b1;
          res_x   = cnt_x + mod_x - s_x;
          count_d = SATURATE ? '0 : res_x[WIDTH-1:0];
        end
      end
    end
    // A set in the same cycle as a clear keeps the flag high.
    ovf_d = ovf_set | (ovf_q & ~clr_flags);
    udf_d = udf_set | (udf_q & ~clr_flags);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign count  = count_q;
  assign wrap   = wrap_q;
  assign ovf    = ovf_q;
  assign udf    = udf_q;
  assign at_max = (count_q == limit);
  assign at_min = (count_q == '0);

endmodule
